digit_entry_buffer: RTL and testbench
=====================================

Name: digit_entry_buffer

Overview:
- Upstream of the seven-segment display driver.
- Captures switch nibbles into a multi-digit buffer, one digit per debounced enter press, with backspace support.
- Presents the assembled digits as one packed bus for the display stage to scan, plus count/full/strobe status for control logic.
- Inputs come from the debouncer outputs; everything runs on one clock domain (the divided clock feeding the display).

Parameters:
- NUM_DIGITS, 4, number of digit slots; legal range 1..7.
- DIGIT_W, 4, bits per digit (hex nibble).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- enter  input  1  debounced level, synchronous to clk; rising edge requests store.
- backspace  input  1  debounced level, synchronous to clk; rising edge requests delete.
- switch_in  input  DIGIT_W  digit value to store.
- digits_out  output  NUM_DIGITS*DIGIT_W  packed buffer; first-entered digit in MS nibble.
- digit_valid  output  NUM_DIGITS  per-slot valid flag; bit i matches nibble i of digits_out.
- count  output  3  number of digits stored, 0..NUM_DIGITS.
- full  output  1  high when count == NUM_DIGITS.
- entry_strobe  output  1  one-cycle pulse when a digit is stored.
- overflow  output  1  one-cycle pulse when enter is rejected because the buffer is full.

Behaviour:
- Reset values:
  - digits_out = 0, digit_valid = 0, count = 0, full = 0, entry_strobe = 0, overflow = 0.
  - Edge-detect registers enter_q and bs_q reset to 1, so an input held high through reset does not produce a phantom edge.
- Edge detect:
  - enter_rise = enter & ~enter_q; bs_rise = backspace & ~bs_q.
  - enter_q and bs_q are updated every cycle.
- Latency:
  - A rise sampled at edge N updates state at edge N.
  - Updated outputs and strobe pulses are visible in the cycle after edge N.
  - Exactly one action per press, regardless of hold length.
- Slot mapping: the k-th stored digit (k = 0 first) occupies digits_out[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] and digit_valid[NUM_DIGITS-1-k].
- State machine (encoded by count): EMPTY (count 0), PARTIAL (0 < count < NUM_DIGITS), FULL (count == NUM_DIGITS).
  - EMPTY + enter_rise: store at slot 0, count = 1; go to PARTIAL, or FULL if NUM_DIGITS == 1.
  - EMPTY + bs_rise: no change, no pulse.
  - PARTIAL + enter_rise: store at slot count, count += 1; go to FULL when count reaches NUM_DIGITS.
  - PARTIAL/FULL + bs_rise: count -= 1; clear that slot's nibble to 0 and its valid bit; go to EMPTY when count reaches 0.
  - FULL + enter_rise: handled per the Optional Feature.
- Stored value: switch_in is sampled at the same edge as enter_rise.
- Simultaneous enter_rise and bs_rise: backspace wins, enter is discarded, no entry_strobe.
- Pulse exclusivity: entry_strobe and overflow are never high in the same cycle.
- full is combinational from count (count == NUM_DIGITS); all other outputs are registered.
- Reset mid-operation: reset has priority over all inputs; buffer returns to EMPTY at that edge.
- count never wraps: it is saturated at both 0 and NUM_DIGITS.

Optional Feature:
- Macro: DIGIT_ENTRY_AUTO_CLEAR_EN.
- Undefined (default):
  - enter_rise in FULL leaves buffer and count unchanged.
  - overflow pulses for one cycle.
- Defined:
  - enter_rise in FULL clears all slots and valid bits, stores switch_in at slot 0, and sets count = 1.
  - entry_strobe pulses; overflow is tied to 0.

Test Plan:
- Reset with enter held high, release reset, keep enter high 10 cycles -> count stays 0, no entry_strobe (phantom edge suppressed).
- Press enter with switch_in = 1,2,3,4 in turn (each held 5 cycles) -> digits_out = 16'h1234, digit_valid = 4'b1111, count = 4, full = 1, exactly 4 single-cycle entry_strobes.
- From 16'h1234, one backspace press -> digits_out = 16'h1230, digit_valid = 4'b1110, count = 3, full = 0; then enter with switch_in = 9 -> 16'h1239, count = 4.
- Backspace pressed with count = 0 -> all outputs unchanged. Enter and backspace rising in the same cycle with count = 2 (16'h5600) -> count = 1, 16'h5000, no strobe.
- FULL with 16'h1234, enter with switch_in = 7:
  - Macro undefined -> overflow one cycle, buffer unchanged.
  - Macro defined -> 16'h7000, count = 1, entry_strobe one cycle.
- Assert reset for one cycle mid-sequence at count = 2 -> next cycle all outputs zero; the following enter stores at slot 0.

Source files
------------

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer
// Captures switch nibbles into a NUM_DIGITS-slot buffer, one digit per rising
// edge of the debounced enter level, with backspace removing the newest digit.
// The first digit entered sits in the most significant nibble of digits_out.
//
// Build option: DIGIT_ENTRY_AUTO_CLEAR_EN
//   undefined - enter while full is rejected and pulses overflow
//   defined   - enter while full restarts the buffer with switch_in in slot 0
//
// Handshake: enter and backspace are plain levels; an action is taken only on
// the cycle a level is first seen high, and entry_strobe / overflow are
// one-cycle pulses reporting that action in the following cycle.
//
// The FSM state register tracks count (EMPTY / PARTIAL / FULL) and is always
// consistent with it, so count serves as the externally visible state.

module digit_entry_buffer #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enter,
    input  logic                          backspace,
    input  logic [DIGIT_W-1:0]            switch_in,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]         digit_valid,
    output logic [2:0]                    count,
    output logic                          full,
    output logic                          entry_strobe,
    output logic                          overflow
);

    localparam logic [2:0] MAX_COUNT = 3'(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t state;
    logic   enter_q;
    logic   bs_q;
    logic   enter_rise;
    logic   bs_rise;

    // Rising-edge detection on the debounced levels
    assign enter_rise = enter & ~enter_q;
    assign bs_rise    = backspace & ~bs_q;

    // full is derived directly from count so it can never disagree with it
    assign full = (count == MAX_COUNT);

    // Maps a digit count onto the FSM state it represents
    function automatic state_t state_for(input logic [2:0] c);
        if (c == 3'd0) begin
            return ST_EMPTY;
        end else if (c == MAX_COUNT) begin
            return ST_FULL;
        end else begin
            return ST_PARTIAL;
        end
    endfunction

    // Buffer FSM: edge registers, slot storage, count and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            // Edge registers start high so a level held through reset is ignored
            enter_q      <= 1'b1;
            bs_q         <= 1'b1;
            state        <= ST_EMPTY;
            digits_out   <= '0;
            digit_valid  <= '0;
            count        <= 3'd0;
            entry_strobe <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            enter_q      <= enter;
            bs_q         <= backspace;
            entry_strobe <= 1'b0;
            overflow     <= 1'b0;

            case (state)
                ST_EMPTY: begin
                    // Backspace on an empty buffer does nothing; it also
                    // suppresses a simultaneous enter
                    if (!bs_rise && enter_rise) begin
                        digits_out[(NUM_DIGITS-1)*DIGIT_W +: DIGIT_W] <= switch_in;
                        digit_valid[NUM_DIGITS-1] <= 1'b1;
                        count        <= 3'd1;
                        state        <= state_for(3'd1);
                        entry_strobe <= 1'b1;
                    end
                end

                ST_PARTIAL: begin
                    if (bs_rise) begin
                        // Newest digit lives at slot count-1
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (i == NUM_DIGITS - int'(count)) begin
                                digits_out[i*DIGIT_W +: DIGIT_W] <= '0;
                                digit_valid[i] <= 1'b0;
                            end
                        end
                        count <= count - 3'd1;
                        state <= state_for(count - 3'd1);
                    end else if (enter_rise) begin
                        // Next free slot is slot count
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (i == NUM_DIGITS - 1 - int'(count)) begin
                                digits_out[i*DIGIT_W +: DIGIT_W] <= switch_in;
                                digit_valid[i] <= 1'b1;
                            end
                        end
                        count        <= count + 3'd1;
                        state        <= state_for(count + 3'd1);
                        entry_strobe <= 1'b1;
                    end
                end

                ST_FULL: begin
                    if (bs_rise) begin
                        // Newest digit is the least significant nibble
                        digits_out[DIGIT_W-1:0] <= '0;
                        digit_valid[0]          <= 1'b0;
                        count <= MAX_COUNT - 3'd1;
                        state <= state_for(MAX_COUNT - 3'd1);
                    end else if (enter_rise) begin
`ifdef DIGIT_ENTRY_AUTO_CLEAR_EN
                        // Restart the entry with this digit as the first one
                        digits_out  <= '0;
                        digit_valid <= '0;
                        digits_out[(NUM_DIGITS-1)*DIGIT_W +: DIGIT_W] <= switch_in;
                        digit_valid[NUM_DIGITS-1] <= 1'b1;
                        count        <= 3'd1;
                        state        <= state_for(3'd1);
                        entry_strobe <= 1'b1;
`else
                        // Reject the digit and report it; the buffer is kept
                        overflow <= 1'b1;
`endif
                    end
                end

                default: begin
                    state <= state_for(count);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb_digit_entry_buffer
// Directed test of digit_entry_buffer (NUM_DIGITS = 4, DIGIT_W = 4).
// Inputs change and outputs are sampled 1ns after the falling clock edge.
// Honours DIGIT_ENTRY_AUTO_CLEAR_EN for the enter-while-full case.

module tb_digit_entry_buffer;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          reset     = 1'b1;
    logic                          enter     = 1'b0;
    logic                          backspace = 1'b0;
    logic [DIGIT_W-1:0]            switch_in = '0;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_out;
    logic [NUM_DIGITS-1:0]         digit_valid;
    logic [2:0]                    count;
    logic                          full;
    logic                          entry_strobe;
    logic                          overflow;

    digit_entry_buffer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enter        (enter),
        .backspace    (backspace),
        .switch_in    (switch_in),
        .digits_out   (digits_out),
        .digit_valid  (digit_valid),
        .count        (count),
        .full         (full),
        .entry_strobe (entry_strobe),
        .overflow     (overflow)
    );

    // ---------------- pulse monitor ----------------
    int strobe_cnt = 0;
    int ovf_cnt    = 0;
    int both_cnt   = 0;
    int long_cnt   = 0;
    logic strobe_prev = 1'b0;
    logic ovf_prev    = 1'b0;

    // Counts pulses and flags any pulse lasting more than one cycle
    always @(negedge clk) begin
        if (entry_strobe === 1'b1) strobe_cnt++;
        if (overflow === 1'b1) ovf_cnt++;
        if (entry_strobe === 1'b1 && overflow === 1'b1) both_cnt++;
        if ((entry_strobe === 1'b1 && strobe_prev) || (overflow === 1'b1 && ovf_prev)) long_cnt++;
        strobe_prev = (entry_strobe === 1'b1);
        ovf_prev    = (overflow === 1'b1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [DIGIT_W-1:0] val);
        switch_in = val;
        enter     = 1'b1;
        repeat (5) tick();
        enter = 1'b0;
        repeat (2) tick();
    endtask

    task automatic press_bs();
        backspace = 1'b1;
        repeat (5) tick();
        backspace = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_state(input string tag, input logic [15:0] exp_d,
                               input logic [3:0] exp_v, input logic [2:0] exp_c,
                               input logic exp_f);
        check({tag, ".digits"}, 32'(digits_out), 32'(exp_d));
        check({tag, ".valid"},  32'(digit_valid), 32'(exp_v));
        check({tag, ".count"},  32'(count), 32'(exp_c));
        check({tag, ".full"},   32'(full), 32'(exp_f));
    endtask

    int s0;
    int o0;

    // ---------------- stimulus ----------------
    initial begin
        // Reset with enter held high: no phantom edge afterwards
        reset = 1'b1;
        enter = 1'b1;
        repeat (3) tick();
        check_state("reset", 16'h0000, 4'b0000, 3'd0, 1'b0);
        check("reset.strobe", 32'(entry_strobe), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        s0 = strobe_cnt;
        reset = 1'b0;
        repeat (10) tick();
        check("phantom.count", 32'(count), 32'd0);
        check("phantom.strobes", 32'(strobe_cnt - s0), 32'd0);
        enter = 1'b0;
        repeat (2) tick();

        // Fill the buffer with 1,2,3,4
        s0 = strobe_cnt;
        press_enter(4'h1);
        check_state("fill1", 16'h1000, 4'b1000, 3'd1, 1'b0);
        press_enter(4'h2);
        press_enter(4'h3);
        check_state("fill3", 16'h1230, 4'b1110, 3'd3, 1'b0);
        press_enter(4'h4);
        check_state("fill4", 16'h1234, 4'b1111, 3'd4, 1'b1);
        check("fill.strobes", 32'(strobe_cnt - s0), 32'd4);

        // Backspace from full, then re-enter
        press_bs();
        check_state("bs_full", 16'h1230, 4'b1110, 3'd3, 1'b0);
        press_enter(4'h9);
        check_state("reenter9", 16'h1239, 4'b1111, 3'd4, 1'b1);
        press_bs();
        press_enter(4'h4);
        check_state("restore", 16'h1234, 4'b1111, 3'd4, 1'b1);

        // Enter while full
        s0 = strobe_cnt;
        o0 = ovf_cnt;
        press_enter(4'h7);
`ifdef DIGIT_ENTRY_AUTO_CLEAR_EN
        check_state("full_enter", 16'h7000, 4'b1000, 3'd1, 1'b0);
        check("full_enter.strobes", 32'(strobe_cnt - s0), 32'd1);
        check("full_enter.overflows", 32'(ovf_cnt - o0), 32'd0);
        press_bs();
`else
        check_state("full_enter", 16'h1234, 4'b1111, 3'd4, 1'b1);
        check("full_enter.strobes", 32'(strobe_cnt - s0), 32'd0);
        check("full_enter.overflows", 32'(ovf_cnt - o0), 32'd1);
        repeat (4) press_bs();
`endif
        check_state("drained", 16'h0000, 4'b0000, 3'd0, 1'b0);

        // Backspace on empty: nothing changes
        s0 = strobe_cnt;
        o0 = ovf_cnt;
        press_bs();
        check_state("bs_empty", 16'h0000, 4'b0000, 3'd0, 1'b0);
        check("bs_empty.pulses", 32'((strobe_cnt - s0) + (ovf_cnt - o0)), 32'd0);

        // Simultaneous enter and backspace: backspace wins
        press_enter(4'h5);
        press_enter(4'h6);
        check_state("pre_both", 16'h5600, 4'b1100, 3'd2, 1'b0);
        s0 = strobe_cnt;
        switch_in = 4'hA;
        enter     = 1'b1;
        backspace = 1'b1;
        repeat (5) tick();
        enter     = 1'b0;
        backspace = 1'b0;
        repeat (2) tick();
        check_state("both", 16'h5000, 4'b1000, 3'd1, 1'b0);
        check("both.strobes", 32'(strobe_cnt - s0), 32'd0);

        // Reset mid-sequence at count 2
        press_enter(4'h8);
        check_state("pre_reset", 16'h5800, 4'b1100, 3'd2, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_state("mid_reset", 16'h0000, 4'b0000, 3'd0, 1'b0);
        tick();
        press_enter(4'h3);
        check_state("after_reset", 16'h3000, 4'b1000, 3'd1, 1'b0);

        // Pulse integrity over the whole run
        check("pulse.exclusive", 32'(both_cnt), 32'd0);
        check("pulse.width", 32'(long_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
